pwm_gate_monitor: RTL

Measures the complementary gate waveforms produced by the DPWM (high-side and low-side switch drives) back into digital counts: period, high-side on-time, low-side on-time and both dead times. It sits between the GPIO gate pins and the closed-loop controller, closing the loop on the duty and dead time actually delivered. It also flags shoot-through (both gates high), missing pulses and stalled switching.

---
 rtl/pwm_gate_monitor_if.sv | 25 ++
 rtl/pwm_gate_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gate_monitor_if.sv
// Measurement result bus from the gate monitor to the closed-loop controller.
// The monitor drives every field; the controller only observes.
interface pwm_gate_monitor_if #(
  parameter int CW = 10
);
  logic [CW-1:0] period;
  logic [CW-1:0] hi_cnt;
  logic [CW-1:0] lo_cnt;
  logic [CW-1:0] dt_f;
  logic [CW-1:0] dt_r;
  logic          meas_valid;
  logic          overlap_fault;
  logic          timeout_fault;
  logic          seq_err;

  modport master (
    output period, hi_cnt, lo_cnt, dt_f, dt_r,
    output meas_valid, overlap_fault, timeout_fault, seq_err
  );

  modport slave (
    input period, hi_cnt, lo_cnt, dt_f, dt_r,
    input meas_valid, overlap_fault, timeout_fault, seq_err
  );
endinterface

// File: rtl/pwm_gate_monitor.sv
// Complementary gate waveform monitor: measures period, on-times and dead
// times of the high/low-side gate drives in clk cycles, and flags
// shoot-through, out-of-order edges and stalled switching.
module pwm_gate_monitor #(
  parameter int CW   = 10,
  parameter int SYNC = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     en_i,
  input  logic                     clr_fault_i,
  input  logic                     gate_hi_i,
  input  logic                     gate_lo_i,
  pwm_gate_monitor_if.master       mon_o
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  // One below the ceiling: incrementing from here would hit 2^CW-1.
  localparam logic [CW-1:0] CNT_SAT = CNT_MAX - CNT_ONE;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_DTF  = 3'd2,
    ST_LO   = 3'd3,
    ST_DTR  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [SYNC-1:0] sync_hi_q, sync_lo_q;
  logic            sh_s, sl_s, sh_prev_q;
  logic [CW-1:0]   per_q, per_d, hi_q, hi_d, dtf_q, dtf_d;
  logic [CW-1:0]   lo_q, lo_d, dtr_q, dtr_d;
  logic            discard_q, discard_d;
  logic            hi_entry_s, publish_s, seq_err_s, overlap_s, timeout_s;
  logic [CW-1:0]   period_q, hi_cnt_q, lo_cnt_q, dt_f_q, dt_r_q;
  logic            meas_valid_q, seq_err_q, overlap_fault_q, timeout_fault_q;

  assign sh_s = sync_hi_q[SYNC-1];
  assign sl_s = sync_lo_q[SYNC-1];

  // Bring both asynchronous gate pins into the clk domain; keep last sh for rise detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_hi_q <= '0;
      sync_lo_q <= '0;
      sh_prev_q <= 1'b0;
    end else begin
      sync_hi_q <= {sync_hi_q[SYNC-2:0], gate_hi_i};
      sync_lo_q <= {sync_lo_q[SYNC-2:0], gate_lo_i};
      sh_prev_q <= sh_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, phase counters and event strobes. Non-idle states act on
  // gate levels so a zero-length dead time still passes through DTF/DTR once.
  always_comb begin
    state_d    = state_q;
    per_d      = per_q;
    hi_d       = hi_q;
    dtf_d      = dtf_q;
    lo_d       = lo_q;
    dtr_d      = dtr_q;
    discard_d  = discard_q;
    hi_entry_s = 1'b0;
    publish_s  = 1'b0;
    seq_err_s  = 1'b0;
    overlap_s  = 1'b0;
    timeout_s  = 1'b0;
    if (!en_i) begin
      state_d   = ST_IDLE;
      per_d     = '0;
      hi_d      = '0;
      dtf_d     = '0;
      lo_d      = '0;
      dtr_d     = '0;
      discard_d = 1'b0;
    end else begin
      overlap_s = sh_s & sl_s;
      if (state_q != ST_IDLE) begin
        per_d = per_q + CNT_ONE;
      end else begin
        per_d = per_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (sh_s && !sh_prev_q && !sl_s) begin
            hi_entry_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HI: begin
          if (overlap_s) begin
            state_d = ST_IDLE;
          end else if (!sh_s) begin
            state_d = ST_DTF;
            dtf_d   = CNT_ONE;
          end else begin
            hi_d = hi_q + CNT_ONE;
          end
        end
        ST_DTF: begin
          if (overlap_s) begin
            state_d = ST_IDLE;
          end else if (sh_s) begin
            seq_err_s  = 1'b1;
            hi_entry_s = 1'b1;
          end else if (sl_s) begin
            state_d = ST_LO;
            lo_d    = CNT_ONE;
          end else begin
            dtf_d = dtf_q + CNT_ONE;
          end
        end
        ST_LO: begin
          if (overlap_s) begin
            state_d = ST_IDLE;
          end else if (!sl_s) begin
            state_d = ST_DTR;
            dtr_d   = CNT_ONE;
          end else begin
            lo_d = lo_q + CNT_ONE;
          end
        end
        ST_DTR: begin
          if (overlap_s) begin
            state_d = ST_IDLE;
          end else if (sh_s) begin
            // A period interrupted by a repeated low pulse is not reported.
            publish_s  = ~discard_q;
            hi_entry_s = 1'b1;
          end else if (sl_s) begin
            seq_err_s = 1'b1;
            discard_d = 1'b1;
            state_d   = ST_LO;
            lo_d      = CNT_ONE;
          end else begin
            dtr_d = dtr_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      if (hi_entry_s) begin
        state_d   = ST_HI;
        per_d     = CNT_ONE;
        hi_d      = CNT_ONE;
        discard_d = 1'b0;
      end else begin
        discard_d = discard_d;
      end
      // The period counter bounds every phase counter, so it alone detects saturation.
      if ((state_q != ST_IDLE) && !hi_entry_s && (per_q == CNT_SAT)) begin
        timeout_s = 1'b1;
        seq_err_s = 1'b0;
        state_d   = ST_IDLE;
      end else begin
        timeout_s = 1'b0;
      end
    end
  end

  // Counters, published measurement, strobes and sticky faults (clear wins over set).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      per_q           <= '0;
      hi_q            <= '0;
      dtf_q           <= '0;
      lo_q            <= '0;
      dtr_q           <= '0;
      discard_q       <= 1'b0;
      period_q        <= '0;
      hi_cnt_q        <= '0;
      lo_cnt_q        <= '0;
      dt_f_q          <= '0;
      dt_r_q          <= '0;
      meas_valid_q    <= 1'b0;
      seq_err_q       <= 1'b0;
      overlap_fault_q <= 1'b0;
      timeout_fault_q <= 1'b0;
    end else begin
      per_q     <= per_d;
      hi_q      <= hi_d;
      dtf_q     <= dtf_d;
      lo_q      <= lo_d;
      dtr_q     <= dtr_d;
      discard_q <= discard_d;
      if (publish_s) begin
        period_q <= per_q;
        hi_cnt_q <= hi_q;
        dt_f_q   <= dtf_q;
        lo_cnt_q <= lo_q;
        dt_r_q   <= dtr_q;
      end
      meas_valid_q    <= publish_s;
      seq_err_q       <= seq_err_s;
      overlap_fault_q <= (overlap_fault_q | overlap_s) & ~clr_fault_i;
      timeout_fault_q <= (timeout_fault_q | timeout_s) & ~clr_fault_i;
    end
  end

  assign mon_o.period        = period_q;
  assign mon_o.hi_cnt        = hi_cnt_q;
  assign mon_o.lo_cnt        = lo_cnt_q;
  assign mon_o.dt_f          = dt_f_q;
  assign mon_o.dt_r          = dt_r_q;
  assign mon_o.meas_valid    = meas_valid_q;
  assign mon_o.seq_err       = seq_err_q;
  assign mon_o.overlap_fault = overlap_fault_q;
  assign mon_o.timeout_fault = timeout_fault_q;

endmodule
